// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// uart_tx_arbiter_if : requester/transmitter handshake bundle for uart_tx_arbiter
// Optional req_lock present when UART_ARB_LOCK_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
    logic [N_REQ-1:0]   req_lock;
`endif
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   done;
    logic               busy;
    logic               err;
    logic               uart_wrreq;
    logic [7:0]         uart_wdata;
    logic               uart_rdy;

`ifdef UART_ARB_LOCK_EN
    modport master (input req, req_data, req_lock, uart_rdy,
                    output ack, done, busy, err, uart_wrreq, uart_wdata);
    modport slave  (output req, req_data, req_lock, uart_rdy,
                    input ack, done, busy, err, uart_wrreq, uart_wdata);
`else
    modport master (input req, req_data, uart_rdy,
                    output ack, done, busy, err, uart_wrreq, uart_wdata);
    modport slave  (output req, req_data, uart_rdy,
                    input ack, done, busy, err, uart_wrreq, uart_wdata);
`endif
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : round-robin sharing of one uart_tx among N_REQ producers
// Optional grant locking enabled by macro UART_ARB_LOCK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  wire logic          clk,
    input  wire logic          nrst,
    uart_tx_arbiter_if.master  bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_START = 2'd1,
        S_WAIT_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_owner;
    logic [PW-1:0]      r_last;
    logic [CW-1:0]      r_cnt;
    logic [N_REQ-1:0]   r_ack;
    logic [N_REQ-1:0]   r_done;
    logic               r_busy;
    logic               r_err;
    logic               r_wrreq;
    logic [7:0]         r_wdata;

    logic [7:0]         w_bytes [N_REQ];
    logic               w_rr_found;
    logic [PW-1:0]      w_rr_idx;
    logic [PW-1:0]      w_scan_idx;
    logic [PW-1:0]      w_winner;

    for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
        assign w_bytes[i] = bus.req_data[8*i +: 8];
    end

    // First pending requester after the last one served, wrapping around.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_last;
        w_scan_idx = r_last;
        for (int k = 1; k <= N_REQ; k++) begin
            w_scan_idx = PW'((int'(r_last) + k) % N_REQ);
            if (!w_rr_found && bus.req[w_scan_idx]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_scan_idx;
            end
        end
    end

`ifdef UART_ARB_LOCK_EN
    logic r_lock;
    logic w_lock_hit;
    assign w_lock_hit = r_lock && bus.req[r_owner];
    assign w_winner   = w_lock_hit ? r_owner : w_rr_idx;
`else
    assign w_winner   = w_rr_idx;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_last  <= PW'(N_REQ - 1);
            r_cnt   <= '0;
            r_ack   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_wrreq <= 1'b0;
            r_wdata <= 8'h00;
`ifdef UART_ARB_LOCK_EN
            r_lock  <= 1'b0;
`endif
        end else begin
            r_ack   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_wrreq <= 1'b0;
            case (r_state)
                S_IDLE: begin
`ifdef UART_ARB_LOCK_EN
                    if (r_lock && !bus.req[r_owner]) begin
                        r_lock <= 1'b0;
                    end
`endif
                    // uart_rdy gating also covers a transmitter still busy after reset
                    if (bus.uart_rdy && (|bus.req)) begin
                        r_owner <= w_winner;
                        r_wdata <= w_bytes[w_winner];
                        r_wrreq <= 1'b1;
                        r_ack   <= N_REQ'(1) << w_winner;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
`ifdef UART_ARB_LOCK_EN
                    if (r_wrreq) begin
                        r_lock <= bus.req_lock[r_owner];
                    end
`endif
                    if (!bus.uart_rdy) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_last  <= r_owner;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`ifdef UART_ARB_LOCK_EN
                        r_lock  <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.uart_rdy) begin
                        r_done  <= N_REQ'(1) << r_owner;
                        r_last  <= r_owner;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack        = r_ack;
    assign bus.done       = r_done;
    assign bus.busy       = r_busy;
    assign bus.err        = r_err;
    assign bus.uart_wrreq = r_wrreq;
    assign bus.uart_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter : directed bench with a frame-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int TO    = 16;
    localparam int FRAME = 40;
    // wrreq sample to done (or to next grant after a reset) with the uart model below
    localparam int LAT   = 41;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int ack_cnt [N];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic logic [18:0] outs();
        return {bus.ack, bus.done, bus.busy, bus.err, bus.uart_wrreq, bus.uart_wdata};
    endfunction

    function automatic int idx_of(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // transmitter: rdy drops the edge after wrreq, back high FRAME-1 cycles later
    logic u_rdy   = 1'b1;
    bit   u_stuck = 1'b0;
    int   u_cnt   = 0;
    assign bus.uart_rdy = u_rdy;

    always @(posedge clk) begin
        if (u_stuck) begin
            u_rdy <= 1'b1;
            u_cnt <= 0;
        end else if (bus.uart_wrreq && u_rdy) begin
            u_rdy <= 1'b0;
            u_cnt <= FRAME - 1;
        end else if (u_cnt != 0) begin
            u_cnt <= u_cnt - 1;
            if (u_cnt == 1) u_rdy <= 1'b1;
        end
    end

    // Reference model: a frame is outstanding from issue until rdy falls and rises again,
    // or until TO cycles pass without rdy falling.
    bit             m_valid = 1'b0;
    bit             m_active, m_seen_low, m_lock;
    int             m_age, m_owner, m_last;
    logic [N-1:0]   exp_ack, exp_done;
    logic           exp_busy, exp_err, exp_wrreq;
    logic [7:0]     exp_wdata;

    always @(posedge clk) begin : model
        automatic int w;
        automatic bit lk;
        lk = m_lock;
        exp_ack   <= '0;
        exp_done  <= '0;
        exp_err   <= 1'b0;
        exp_wrreq <= 1'b0;
        if (!nrst) begin
            m_valid   <= 1'b1;
            m_active  <= 1'b0;
            m_last    <= N - 1;
            m_lock    <= 1'b0;
            m_owner   <= 0;
            exp_busy  <= 1'b0;
            exp_wdata <= 8'h00;
        end else if (!m_active) begin
`ifdef UART_ARB_LOCK_EN
            if (lk && !bus.req[m_owner]) lk = 1'b0;
`endif
            if (bus.uart_rdy && (|bus.req)) begin
                w = (lk && bus.req[m_owner]) ? m_owner : rr_pick(bus.req, m_last);
                exp_ack[w] <= 1'b1;
                exp_wrreq  <= 1'b1;
                exp_wdata  <= bus.req_data[8*w +: 8];
                exp_busy   <= 1'b1;
                m_owner    <= w;
                m_active   <= 1'b1;
                m_age      <= 0;
                m_seen_low <= 1'b0;
            end
            m_lock <= lk;
        end else begin
`ifdef UART_ARB_LOCK_EN
            if (m_age == 0) lk = bus.req_lock[m_owner];
`endif
            if (!m_seen_low) begin
                if (!bus.uart_rdy) begin
                    m_seen_low <= 1'b1;
                end else if (m_age + 1 == TO) begin
                    exp_err  <= 1'b1;
                    exp_busy <= 1'b0;
                    m_active <= 1'b0;
                    m_last   <= m_owner;
                    lk       = 1'b0;
                end
            end else if (bus.uart_rdy) begin
                exp_done[m_owner] <= 1'b1;
                exp_busy <= 1'b0;
                m_active <= 1'b0;
                m_last   <= m_owner;
            end
            m_age  <= m_age + 1;
            m_lock <= lk;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cycle_outputs", outs(),
                {exp_ack, exp_done, exp_busy, exp_err, exp_wrreq, exp_wdata});
            for (int i = 0; i < N; i++) if (bus.ack[i]) ack_cnt[i]++;
        end
    end

    // which: 0 = wrreq, 1 = any done, 2 = err; returns at the negedge where it is seen
    task automatic wait_ev(input int which, input int bound, input string name, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            case (which)
                0:       got = bus.uart_wrreq;
                1:       got = |bus.done;
                default: got = bus.err;
            endcase
        end
        if (!got) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        bit got;
        int t0, td, a1, a3;
        int order2 [5] = '{0, 1, 2, 3, 0};
        logic [7:0] bytes2 [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        int order3 [2] = '{2, 0};
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        bus.req      = '0;
        bus.req_data = '0;
`ifdef UART_ARB_LOCK_EN
        bus.req_lock = '0;
`endif
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        nrst = 1'b1;

        // single byte from requester 1
        bus.req      = 4'b0010;
        bus.req_data = 32'h0000_A500;
        wait_ev(0, 10, "t1_issue", got);
        t0 = cyc;
        chk("t1_ack", bus.ack, 4'b0010);
        chk("t1_wdata", bus.uart_wdata, 8'hA5);
        bus.req = '0;
        wait_ev(1, 100, "t1_done", got);
        chk("t1_done", bus.done, 4'b0010);
        chk("t1_latency", cyc - t0, LAT);

        // all requesting from reset: 0,1,2,3,0 with one idle cycle between frames
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        bus.req      = 4'b1111;
        bus.req_data = 32'h1312_1110;
        td = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ev(0, 100, "t2_issue", got);
            chk("t2_grant", idx_of(bus.ack), order2[k]);
            chk("t2_wdata", bus.uart_wdata, bytes2[k]);
            if (k > 0) chk("t2_gap", cyc - td, 1);
            if (k == 4) bus.req = 4'b0101;
            wait_ev(1, 100, "t2_done", got);
            td = cyc;
        end

        // after grant 0 with req=0101: 2 then 0, never 1 or 3
        a1 = ack_cnt[1];
        a3 = ack_cnt[3];
        for (int k = 0; k < 2; k++) begin
            wait_ev(0, 100, "t3_issue", got);
            chk("t3_grant", idx_of(bus.ack), order3[k]);
            if (k == 1) bus.req = '0;
            wait_ev(1, 100, "t3_done", got);
        end
        chk("t3_no_ack1", ack_cnt[1] - a1, 0);
        chk("t3_no_ack3", ack_cnt[3] - a3, 0);

        // transmitter never starts: err after TO cycles, then rotation continues
        u_stuck = 1'b1;
        bus.req = 4'b1111;
        wait_ev(0, 10, "t4_issue", got);
        chk("t4_grant", idx_of(bus.ack), 1);
        t0 = cyc;
        wait_ev(2, 40, "t4_err", got);
        chk("t4_err_delay", cyc - t0, TO);
        chk("t4_busy", bus.busy, 0);
        chk("t4_done", bus.done, 0);
        u_stuck = 1'b0;
        wait_ev(0, 5, "t4_reissue", got);
        chk("t4_next_grant", idx_of(bus.ack), 2);
        bus.req = '0;
        wait_ev(1, 100, "t4_done", got);

        // reset during a frame: no issue until the transmitter is idle, then requester 0
        bus.req = 4'b1000;
        wait_ev(0, 10, "t5_issue", got);
        chk("t5_grant", idx_of(bus.ack), 3);
        t0 = cyc;
        bus.req = '0;
        repeat (10) @(negedge clk);
        chk("t5_rdy_low", bus.uart_rdy, 0);
        nrst = 1'b0;
        @(negedge clk);
        chk("t5_reset_outputs", outs(), 0);
        nrst = 1'b1;
        bus.req = 4'b1111;
        wait_ev(0, 100, "t5_reissue", got);
        chk("t5_first_grant", idx_of(bus.ack), 0);
        chk("t5_issue_delay", cyc - t0, LAT);
        bus.req = '0;
        wait_ev(1, 100, "t5_done", got);

`ifdef UART_ARB_LOCK_EN
        // locked owner keeps the grant until req_lock drops
        bus.req      = 4'b0110;
        bus.req_lock = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            wait_ev(0, 100, "t6_issue", got);
            chk("t6_lock_grant", idx_of(bus.ack), 1);
            if (k == 2) bus.req_lock = '0;
            wait_ev(1, 100, "t6_done", got);
        end
        wait_ev(0, 100, "t6_unlock_issue", got);
        chk("t6_unlock_grant", idx_of(bus.ack), 2);
        bus.req = '0;
        wait_ev(1, 100, "t6_unlock_done", got);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
